// File: rtl/space_invaders_pkg.sv
// space_invaders_pkg: colour codes, screen/ship geometry, bomb timing constants and
// the bomb state enum shared by the Space Invaders game blocks.
package space_invaders_pkg;

  localparam logic [2:0]  BACKGROUND     = 3'd0;
  localparam logic [2:0]  EXPLOSION      = 3'd4;
  localparam logic [2:0]  BOMB           = 3'd5;

  localparam logic [10:0] RADIUS         = 11'd4;
  localparam logic [10:0] SCREEN_HEIGHT  = 11'd480;
  localparam logic [10:0] SHIP_WIDTH     = 11'd60;
  localparam logic [10:0] SHIP_HEIGHT    = 11'd30;
  localparam logic [10:0] V_OFFSET       = 11'd10;
  localparam logic [10:0] STEP_MOTION    = 11'd2;

  localparam logic [6:0]  COOLDOWN_MIN   = 7'd30;
  localparam logic [3:0]  EXPLODE_FRAMES = 4'd8;
  localparam logic [15:0] LFSR_SEED      = 16'hACE1;

  // Derived geometry, kept 11 bits wide so coordinate sums never wrap.
  localparam logic [10:0] HIT_RANGE      = RADIUS << 1;
  localparam logic [10:0] SHIP_TOP       = SCREEN_HEIGHT - V_OFFSET - SHIP_HEIGHT;
  localparam logic [10:0] SHIP_HALF      = SHIP_WIDTH >> 1;

  typedef enum logic [1:0] {
    COOLDOWN,
    REQUEST,
    FALLING,
    EXPLODE
  } bomb_state_t;

  function automatic logic [10:0] absDiff(input logic [10:0] a, input logic [10:0] b);
    return (a >= b) ? (a - b) : (b - a);
  endfunction

endpackage

// File: rtl/alien_bomb_if.sv
// alien_bomb_if: shooter request handshake between the bomb (master) and the alien grid (slave).
interface alien_bomb_if;

  logic       fireReq;
  logic       fireAck;
  logic [9:0] shooterX;
  logic [9:0] shooterY;

  modport master (
    output fireReq,
    input  fireAck,
    input  shooterX,
    input  shooterY
  );

  modport slave (
    input  fireReq,
    output fireAck,
    output shooterX,
    output shooterY
  );

endinterface

// File: rtl/alien_bomb_lfsr.sv
// bomb_lfsr: 16-bit Fibonacci LFSR (taps 16,14,13,11) that advances on every enabled clock;
// only the low OUT_W bits are exported.
module bomb_lfsr #(
  parameter int OUT_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_enable,
  input  logic [15:0]      i_seed,
  output logic [OUT_W-1:0] o_bits
);

  logic [15:0] r_lfsr;
  logic        w_feedback;

  assign w_feedback = r_lfsr[0] ^ r_lfsr[2] ^ r_lfsr[3] ^ r_lfsr[5];

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_lfsr <= i_seed;
    end else if (i_enable) begin
      r_lfsr <= {w_feedback, r_lfsr[15:1]};
    end
  end

  assign o_bits = r_lfsr[OUT_W-1:0];

endmodule

// File: rtl/alien_bomb.sv
// alien_bomb: the single falling alien bomb -- random cooldown, shooter request, fall,
// laser/ship collisions and pixel colour. Define ALIEN_BOMB_EXPLODE_EN for the explosion phase.
module alien_bomb
  import space_invaders_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  input  logic         enable,
  input  logic         frameTick,
  alien_bomb_if.master grid,
  input  logic [9:0]   gunPosition,
  input  logic         laserActive,
  input  logic [9:0]   xLaser,
  input  logic [9:0]   yLaser,
  input  logic [9:0]   hPos,
  input  logic [9:0]   vPos,
  output logic [9:0]   xBomb,
  output logic [9:0]   yBomb,
  output logic         hitShip,
  output logic         bombShot,
  output logic [2:0]   colorBomb
);

  bomb_state_t r_state;
  logic [6:0]  r_cooldown;
  logic [9:0]  r_xBomb;
  logic [9:0]  r_yBomb;
  logic        r_fireReq;
  logic        r_hitShip;
  logic        r_bombShot;
`ifdef ALIEN_BOMB_EXPLODE_EN
  logic [3:0]  r_explode;
`endif

  logic [5:0]  w_random;
  logic [10:0] w_xb;
  logic [10:0] w_yb;
  logic [10:0] w_dxPix;
  logic [10:0] w_dyPix;
  logic        w_laserHit;
  logic        w_shipHit;
  logic        w_offScreen;
  logic [6:0]  w_cooldownLoad;

  bomb_lfsr #(.OUT_W(6)) u_lfsr (
    .clk      (clk),
    .reset    (reset),
    .i_enable (enable),
    .i_seed   (LFSR_SEED),
    .o_bits   (w_random)
  );

  assign w_xb    = {1'b0, r_xBomb};
  assign w_yb    = {1'b0, r_yBomb};
  assign w_dxPix = absDiff({1'b0, hPos}, w_xb);
  assign w_dyPix = absDiff({1'b0, vPos}, w_yb);

  assign w_laserHit  = laserActive
                    && (absDiff({1'b0, xLaser}, w_xb) <= HIT_RANGE)
                    && (absDiff({1'b0, yLaser}, w_yb) <= HIT_RANGE);
  assign w_shipHit   = ((w_yb + RADIUS) >= SHIP_TOP)
                    && (absDiff(w_xb, {1'b0, gunPosition}) <= SHIP_HALF);
  assign w_offScreen = (w_yb + RADIUS + STEP_MOTION) >= SCREEN_HEIGHT;

  assign w_cooldownLoad = COOLDOWN_MIN + {1'b0, w_random};

  // Bomb lifecycle; pulses are cleared every cycle so they last exactly one clock.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state    <= COOLDOWN;
      r_cooldown <= COOLDOWN_MIN;
      r_xBomb    <= '0;
      r_yBomb    <= '0;
      r_fireReq  <= 1'b0;
      r_hitShip  <= 1'b0;
      r_bombShot <= 1'b0;
`ifdef ALIEN_BOMB_EXPLODE_EN
      r_explode  <= '0;
`endif
    end else begin
      r_hitShip  <= 1'b0;
      r_bombShot <= 1'b0;
      if (enable) begin
        case (r_state)
          COOLDOWN: begin
            if (frameTick) begin
              if (r_cooldown <= 7'd1) begin
                r_state   <= REQUEST;
                r_fireReq <= 1'b1;
              end else begin
                r_cooldown <= r_cooldown - 7'd1;
              end
            end
          end
          REQUEST: begin
            if (grid.fireAck) begin
              r_xBomb   <= grid.shooterX;
              r_yBomb   <= grid.shooterY + RADIUS[9:0];
              r_fireReq <= 1'b0;
              r_state   <= FALLING;
            end
          end
          FALLING: begin
            if (frameTick) begin
              // Laser has priority: a simultaneous ship hit only yields bombShot.
              if (w_laserHit || w_shipHit) begin
                r_bombShot <= w_laserHit;
                r_hitShip  <= !w_laserHit;
`ifdef ALIEN_BOMB_EXPLODE_EN
                r_state    <= EXPLODE;
                r_explode  <= EXPLODE_FRAMES;
`else
                r_state    <= COOLDOWN;
                r_cooldown <= w_cooldownLoad;
`endif
              end else if (w_offScreen) begin
                r_state    <= COOLDOWN;
                r_cooldown <= w_cooldownLoad;
              end else begin
                r_yBomb <= r_yBomb + STEP_MOTION[9:0];
              end
            end
          end
          EXPLODE: begin
`ifdef ALIEN_BOMB_EXPLODE_EN
            if (frameTick) begin
              if (r_explode <= 4'd1) begin
                r_state    <= COOLDOWN;
                r_cooldown <= w_cooldownLoad;
              end else begin
                r_explode <= r_explode - 4'd1;
              end
            end
`else
            r_state    <= COOLDOWN;
            r_cooldown <= w_cooldownLoad;
`endif
          end
          default: begin
            r_state <= COOLDOWN;
          end
        endcase
      end
    end
  end

  always_comb begin
    colorBomb = BACKGROUND;
    if ((r_state == FALLING) && (w_dxPix <= RADIUS) && (w_dyPix <= RADIUS)) begin
      colorBomb = BOMB;
    end
`ifdef ALIEN_BOMB_EXPLODE_EN
    else if ((r_state == EXPLODE) && (w_dxPix <= HIT_RANGE) && (w_dyPix <= HIT_RANGE)) begin
      colorBomb = EXPLOSION;
    end
`endif
  end

  assign grid.fireReq = r_fireReq & enable;
  assign xBomb        = r_xBomb;
  assign yBomb        = r_yBomb;
  assign hitShip      = r_hitShip;
  assign bombShot     = r_bombShot;

endmodule

// File: tb/tb_alien_bomb.sv
// tb_alien_bomb: scoreboard bench for alien_bomb; a frame-level model predicts request/hit/shot
// events and a monitor matches them against what the DUT presents. Honours ALIEN_BOMB_EXPLODE_EN.
module tb_alien_bomb;

  typedef struct {
    int kind;
    int xb;
    int yb;
  } event_t;

  localparam int EV_REQ  = 0;
  localparam int EV_HIT  = 1;
  localparam int EV_SHOT = 2;
  localparam int EV_EXIT = 3;

  logic       clk;
  logic       reset;
  logic       enable;
  logic       frameTick;
  logic       laserActive;
  logic [9:0] gunPosition;
  logic [9:0] xLaser;
  logic [9:0] yLaser;
  logic [9:0] hPos;
  logic [9:0] vPos;
  logic [9:0] xBomb;
  logic [9:0] yBomb;
  logic       hitShip;
  logic       bombShot;
  logic [2:0] colorBomb;

  alien_bomb_if grid ();

  alien_bomb dut (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .frameTick   (frameTick),
    .grid        (grid),
    .gunPosition (gunPosition),
    .laserActive (laserActive),
    .xLaser      (xLaser),
    .yLaser      (yLaser),
    .hPos        (hPos),
    .vPos        (vPos),
    .xBomb       (xBomb),
    .yBomb       (yBomb),
    .hitShip     (hitShip),
    .bombShot    (bombShot),
    .colorBomb   (colorBomb)
  );

  int          testsRun    = 0;
  int          testsFailed = 0;
  event_t      expQ[$];
  logic [15:0] tbLfsr;
  logic [15:0] tickLfsr;
  int          mX;
  int          mY;
  int          mCd;
  logic        prevFireReq;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #5000000;
    $display("[TB] FAIL watchdog: simulation time limit reached, required earlier finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // The random source as described: shift right, feedback from bits 0,2,3,5 into bit 15.
  function automatic logic [15:0] lfsrNext(input logic [15:0] v);
    int unsigned s;
    int unsigned b;
    s = {16'd0, v};
    b = (s ^ (s >> 2) ^ (s >> 3) ^ (s >> 5)) & 32'd1;
    return 16'((s >> 1) | (b << 15));
  endfunction

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  always @(posedge clk) begin
    if (!reset) tbLfsr <= 16'hACE1;
    else if (enable) tbLfsr <= lfsrNext(tbLfsr);
  end

  task automatic checkOutput(input string name, input int actual, input int required);
    testsRun++;
    if (actual != required) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0d, required %0d (t=%0t)", name, actual, required, $time);
    end
  endtask

  task automatic scoreEvent(input int kind);
    event_t e;
    if (expQ.size() == 0) begin
      checkOutput("unexpectedEvent", kind, -1);
      return;
    end
    e = expQ.pop_front();
    checkOutput("eventKind", kind, e.kind);
    if (kind != EV_REQ) begin
      checkOutput("eventXBomb", int'(xBomb), e.xb);
      checkOutput("eventYBomb", int'(yBomb), e.yb);
    end
  endtask

  // Monitor: fireReq rising edges and hit/shot pulses are the DUT's presented events.
  always @(posedge clk) begin
    #1;
    if (enable && reset) begin
      if (grid.fireReq && !prevFireReq) scoreEvent(EV_REQ);
      prevFireReq = grid.fireReq;
    end
    if (hitShip) scoreEvent(EV_HIT);
    if (bombShot) scoreEvent(EV_SHOT);
  end

  // One frame: tick high for one clock, then low for one clock.
  task automatic applyStimulus();
    @(negedge clk);
    frameTick = 1'b1;
    tickLfsr  = tbLfsr;
    @(negedge clk);
    frameTick = 1'b0;
  endtask

  task automatic runCooldown();
    checkOutput("fireReqLowInCooldown", int'(grid.fireReq), 0);
    for (int i = 1; i <= mCd; i++) begin
      if (i == mCd) expQ.push_back('{EV_REQ, 0, 0});
      applyStimulus();
    end
    checkOutput("fireReqHigh", int'(grid.fireReq), 1);
  endtask

  task automatic launch(input int x, input int y);
    @(negedge clk);
    grid.fireAck  = 1'b1;
    grid.shooterX = 10'(x);
    grid.shooterY = 10'(y);
    @(negedge clk);
    grid.fireAck  = 1'b0;
    grid.shooterX = 10'($urandom_range(0, 1023));
    grid.shooterY = 10'($urandom_range(0, 1023));
    mX = x;
    mY = y + 4;
    checkOutput("launchX", int'(xBomb), mX);
    checkOutput("launchY", int'(yBomb), mY);
    checkOutput("fireReqDropped", int'(grid.fireReq), 0);
  endtask

  task automatic checkPixel(input int dh, input int dv);
    hPos = 10'(mX + dh);
    vPos = 10'(mY + dv);
    #1;
    checkOutput("pixelColour", int'(colorBomb), (iabs(dh) <= 4 && iabs(dv) <= 4) ? 5 : 0);
  endtask

  task automatic endFlight();
`ifdef ALIEN_BOMB_EXPLODE_EN
    for (int i = 0; i < 8; i++) begin
      hPos = 10'(mX + 6);
      vPos = 10'(mY - 6);
      #1;
      checkOutput("explodeColour", int'(colorBomb), 4);
      applyStimulus();
    end
    hPos = 10'(mX);
    vPos = 10'(mY);
    #1;
    checkOutput("afterExplodeColour", int'(colorBomb), 0);
`endif
    mCd = 30 + int'(tickLfsr[5:0]);
  endtask

  // Frame-level model of one falling tick, in the listed priority order.
  task automatic fallTick(output int outcome);
    bit laserHit;
    bit shipHit;
    bit offScreen;
    laserHit  = laserActive && iabs(int'(xLaser) - mX) <= 8 && iabs(int'(yLaser) - mY) <= 8;
    shipHit   = (mY + 4 >= 440) && iabs(mX - int'(gunPosition)) <= 30;
    offScreen = (mY + 4 + 2 >= 480);
    if (laserHit) expQ.push_back('{EV_SHOT, mX, mY});
    else if (shipHit) expQ.push_back('{EV_HIT, mX, mY});
    applyStimulus();
    if (laserHit || shipHit) begin
      outcome = laserHit ? EV_SHOT : EV_HIT;
      endFlight();
    end else if (offScreen) begin
      outcome = EV_EXIT;
      mCd = 30 + int'(tickLfsr[5:0]);
    end else begin
      outcome = 0;
      mY += 2;
    end
  endtask

  task automatic fly(input bit randomLaser);
    int n;
    int outcome;
    n = 0;
    outcome = 0;
    while (outcome == 0 && n < 400) begin
      if (randomLaser) begin
        if ($urandom_range(0, 15) == 0) begin
          laserActive = 1'b1;
          xLaser = 10'(mX + int'($urandom_range(0, 24)) - 12);
          yLaser = 10'(mY + int'($urandom_range(0, 24)) - 12);
        end else begin
          laserActive = 1'b0;
        end
      end
      fallTick(outcome);
      n++;
    end
    laserActive = 1'b0;
    if (outcome == 0) checkOutput("flightEnds", 0, 1);
  endtask

  initial begin
    int outcome;
    reset = 1'b0;
    enable = 1'b0;
    frameTick = 1'b0;
    laserActive = 1'b0;
    gunPosition = 10'd200;
    xLaser = '0;
    yLaser = '0;
    hPos = '0;
    vPos = '0;
    grid.fireAck = 1'b0;
    grid.shooterX = '0;
    grid.shooterY = '0;
    prevFireReq = 1'b0;

    repeat (3) @(negedge clk);
    checkOutput("resetXBomb", int'(xBomb), 0);
    checkOutput("resetYBomb", int'(yBomb), 0);
    checkOutput("resetFireReq", int'(grid.fireReq), 0);
    checkOutput("resetHitShip", int'(hitShip), 0);
    checkOutput("resetBombShot", int'(bombShot), 0);
    checkOutput("resetColour", int'(colorBomb), 0);
    reset = 1'b1;
    enable = 1'b1;
    mCd = 30;

    // First cooldown is exactly 30 frames; then the request must persist without an ack.
    runCooldown();
    repeat (3) applyStimulus();
    checkOutput("requestHeld", int'(grid.fireReq), 1);
    @(negedge clk);
    enable = 1'b0;
    #1;
    checkOutput("fireReqGatedByEnable", int'(grid.fireReq), 0);
    @(negedge clk);
    enable = 1'b1;

    // Launch at (200,100), fall, draw, then strike the ship at x=200.
    gunPosition = 10'd200;
    launch(200, 100);
    repeat (5) fallTick(outcome);
    checkOutput("yAfterFiveTicks", int'(yBomb), mY);
    checkPixel(0, 0);
    checkPixel(5, 0);
    for (int i = 0; i < 4; i++) checkPixel(int'($urandom_range(0, 12)) - 6, int'($urandom_range(0, 12)) - 6);
    fly(1'b0);

    // Same drop with the ship away: leaves the screen silently.
    runCooldown();
    gunPosition = 10'd300;
    launch(200, 100);
    fly(1'b0);

    // Laser at (203,150) meets the bomb at (200,146).
    runCooldown();
    gunPosition = 10'd500;
    launch(200, 100);
    while (mY < 146) fallTick(outcome);
    laserActive = 1'b1;
    xLaser = 10'd203;
    yLaser = 10'd150;
    fallTick(outcome);
    laserActive = 1'b0;

    // Laser and ship both in range on the same tick.
    runCooldown();
    gunPosition = 10'd320;
    launch(320, 380);
    while (mY < 436) fallTick(outcome);
    laserActive = 1'b1;
    xLaser = 10'(mX);
    yLaser = 10'(mY + 3);
    fallTick(outcome);
    laserActive = 1'b0;

    // An ack outside REQUEST must not move the bomb.
    @(negedge clk);
    grid.fireAck = 1'b1;
    grid.shooterX = 10'd77;
    grid.shooterY = 10'd77;
    @(negedge clk);
    grid.fireAck = 1'b0;
    checkOutput("ackIgnoredX", int'(xBomb), mX);
    checkOutput("ackIgnoredY", int'(yBomb), mY);

    // Freeze mid-flight for 100 frames.
    runCooldown();
    gunPosition = 10'($urandom_range(0, 639));
    launch(int'($urandom_range(40, 600)), int'($urandom_range(20, 200)));
    repeat (10) fallTick(outcome);
    enable = 1'b0;
    repeat (100) applyStimulus();
    checkOutput("frozenXBomb", int'(xBomb), mX);
    checkOutput("frozenYBomb", int'(yBomb), mY);
    enable = 1'b1;
    fly(1'b1);

    // Randomised flights.
    for (int f = 0; f < 6; f++) begin
      runCooldown();
      launch(int'($urandom_range(40, 600)), int'($urandom_range(20, 300)));
      if ($urandom_range(0, 1) == 1) gunPosition = 10'(mX + int'($urandom_range(0, 80)) - 40);
      else gunPosition = 10'($urandom_range(0, 639));
      fly(1'b1);
    end

    // Reset in mid-flight.
    runCooldown();
    gunPosition = 10'd600;
    launch(300, 50);
    repeat (20) fallTick(outcome);
    hPos = 10'(mX);
    vPos = 10'(mY);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checkOutput("midResetXBomb", int'(xBomb), 0);
    checkOutput("midResetYBomb", int'(yBomb), 0);
    checkOutput("midResetFireReq", int'(grid.fireReq), 0);
    checkOutput("midResetHitShip", int'(hitShip), 0);
    checkOutput("midResetBombShot", int'(bombShot), 0);
    checkOutput("midResetColour", int'(colorBomb), 0);
    reset = 1'b1;
    mCd = 30;
    runCooldown();
    launch(int'($urandom_range(40, 600)), int'($urandom_range(20, 300)));
    gunPosition = 10'(mX);
    fly(1'b0);
    runCooldown();

    repeat (3) @(negedge clk);
    checkOutput("scoreboardDrained", expQ.size(), 0);
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/alien_bomb.md
# alien_bomb

Generates the single falling alien bomb for the Space Invaders game, the downward counterpart of the player's laser. It requests a shooter from the alien grid after a pseudo-random cooldown, then moves the bomb down the screen one step per frame. It detects collisions with the player laser and with the ship, and drives the bomb's pixel colour for the VGA mixer. It sits beside the laser and alien-grid blocks, on the pixel clock, gated by the game `enable`.

## Interface
- `BACKGROUND`, 0, background colour code
- `BOMB`, 5, bomb colour code
- `EXPLOSION`, 4, explosion colour code
- `RADIUS`, 4, bomb half-size in pixels
- `SCREEN_HEIGHT`, 480, visible lines
- `SHIP_WIDTH`, 60, ship width in pixels
- `SHIP_HEIGHT`, 30, ship height in pixels
- `V_OFFSET`, 10, gap in pixels between the screen bottom and the ship
- `STEP_MOTION`, 2, pixels of bomb travel per frame
- `COOLDOWN_MIN`, 30, minimum number of frames between bombs
- `EXPLODE_FRAMES`, 8, explosion duration in frames
- `clk  in  1` pixel clock
- `reset  in  1` synchronous, active-low
- `enable  in  1` game running; low freezes all state
- `frameTick  in  1` one-cycle pulse per frame
- `fireAck  in  1` grid accepts the request; shooter coordinates are valid in this cycle
- `shooterX  in  10` centre x of the firing alien
- `shooterY  in  10` bottom y of the firing alien
- `gunPosition  in  10` ship centre x
- `laserActive  in  1` player laser is in flight
- `xLaser`, `yLaser`  in  10 each: laser centre
- `hPos`, `vPos`  in  10 each: current pixel
- `fireReq  out  1` request for a shooter
- `xBomb`, `yBomb`  out  10 each: bomb centre
- `hitShip  out  1` one-cycle pulse when the bomb hits the ship
- `bombShot  out  1` one-cycle pulse when the laser destroys the bomb
- `colorBomb  out  3` pixel colour

## Operation
- States: COOLDOWN, REQUEST, FALLING, EXPLODE.
- Reset values:
  - state is COOLDOWN, with the counter set to `COOLDOWN_MIN`.
  - `xBomb`, `yBomb` = 0.
  - `fireReq`, `hitShip`, `bombShot` = 0.
  - `colorBomb` = `BACKGROUND`.
  - LFSR is seeded with 16'hACE1.
- LFSR: 16-bit Fibonacci, taps 16,14,13,11; it advances every enabled clock.
- COOLDOWN: the counter decrements on each `frameTick`. When it reaches 0 → REQUEST.
- REQUEST: `fireReq` is held high until a cycle with `fireAck` = 1.
  - On that cycle: `xBomb` ← `shooterX`, `yBomb` ← `shooterY` + `RADIUS`, → FALLING, and `fireReq` drops the next cycle.
  - `fireAck` outside REQUEST is ignored.
  - If the grid never acks (no aliens left), the block stays in REQUEST.
- FALLING: on each `frameTick`, exactly one of the following applies, in priority order:
  1. Laser hit: `laserActive`, |`xLaser`−`xBomb`| ≤ 2·`RADIUS` and |`yLaser`−`yBomb`| ≤ 2·`RADIUS` → `bombShot` pulse, then end.
  2. Ship hit: `yBomb`+`RADIUS` ≥ `SCREEN_HEIGHT`−`V_OFFSET`−`SHIP_HEIGHT` and |`xBomb`−`gunPosition`| ≤ `SHIP_WIDTH`/2 → `hitShip` pulse, then end.
  3. Off-screen: `yBomb`+`RADIUS`+`STEP_MOTION` ≥ `SCREEN_HEIGHT` → COOLDOWN with no pulse.
  4. Otherwise `yBomb` += `STEP_MOTION`.
- "End" means EXPLODE if the explosion feature is compiled in, else COOLDOWN.
- Every entry to COOLDOWN loads `COOLDOWN_MIN` + `lfsr[5:0]`, giving 30..93 frames.
- Arithmetic: all coordinate math uses 11-bit unsigned zero-extension; absolute differences are computed by compare-then-subtract, so there is no wrap.
- `colorBomb`, combinational from registered state:
  - FALLING and |`hPos`−`xBomb`| ≤ `RADIUS` and |`vPos`−`yBomb`| ≤ `RADIUS` → `BOMB`.
  - EXPLODE within 2·`RADIUS` → `EXPLOSION`.
  - Otherwise `BACKGROUND`.
- `enable` low: state, counters, coordinates and the LFSR hold; `fireReq` is forced to 0; no pulses; `frameTick` is ignored.

## Timing
- `hitShip` / `bombShot` assert the cycle after the qualifying `frameTick` and last exactly 1 cycle.
- Launch: `fireAck` at cycle t → `xBomb`/`yBomb` valid at t+1; first motion on the next `frameTick`.
- Reset asserted mid-flight: at the next edge all outputs take their reset values; no pulse is emitted.
- Laser and ship conditions true on the same tick: only `bombShot` is emitted.

## Configuration
- `ALIEN_BOMB_EXPLODE_EN` defined: EXPLODE state present. `xBomb`/`yBomb` freeze at the hit point for `EXPLODE_FRAMES` frames, drawing `EXPLOSION`, then → COOLDOWN.
- Undefined: EXPLODE and its counter are absent; a hit goes directly to COOLDOWN; `colorBomb` never shows `EXPLOSION`.

## Structure
- Shared package `space_invaders_pkg`: colour codes, screen and ship dimensions, `STEP_MOTION`, and the bomb state enum.
- One sub-module, `bomb_lfsr`: 16-bit LFSR with enable and seed.

## Test plan
- Reset, then `enable` with 30 `frameTick`s → `fireReq` = 1 after the 30th tick; all outputs were 0 / `BACKGROUND` before that.
- `fireAck` with `shooterX` = 200, `shooterY` = 100 → `xBomb` = 200, `yBomb` = 104; after 5 ticks `yBomb` = 114; pixel (200,114) = `BOMB`, (205,114) = `BACKGROUND`.
- `gunPosition` = 200, bomb falling → `hitShip` pulse on the tick where `yBomb`+4 ≥ 440; with `gunPosition` = 300 the bomb instead exits with no pulse.
- `laserActive`, laser at (203,150), bomb at (200,146) → `bombShot` pulse; with the ship also in range on the same tick → `bombShot` only.
- `enable` low for 100 ticks mid-flight → `yBomb` and LFSR unchanged; `reset` low mid-flight → all outputs return to reset values.
- With `ALIEN_BOMB_EXPLODE_EN` defined → `EXPLOSION` is drawn for 8 frames after a hit, then cooldown begins.
